// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-ported memory bus between the core's
// instruction-fetch port and data port, one transaction at a time.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; arbitrate and latch the winner's payload
//   REQ     | mem_req_o asserted with latched payload, waiting for mem_gnt_i
//   RESP    | request accepted, waiting for mem_rvalid_i
//   ERR     | one-cycle error response (misaligned access or timeout)
module riscv_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ireq_i,
  input  logic [31:0] iaddr_i,
  output logic        igrant_o,
  output logic        irvalid_o,
  output logic [31:0] irdata_o,
  output logic        ierr_o,
  input  logic        dreq_i,
  input  logic        dwe_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  output logic        dgrant_o,
  output logic        drvalid_o,
  output logic [31:0] drdata_o,
  output logic        derr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        owner_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        idle;
  logic        i_win;
  logic        d_win;
  logic        i_misalign;
  logic        d_misalign;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        resp_hit;
  logic        err_st;
  logic        in_req;

  // Arbitration: data wins by default, instruction wins once starved long enough.
  always_comb begin
    idle     = (state_q == ST_IDLE);
    i_win    = idle & ireq_i & (~dreq_i | (starve_q == STARVE_MAX));
    d_win    = idle & dreq_i & ~i_win;
    // Grants are gated by reset so every output reads 0 while reset is held.
    igrant_o = i_win & ~reset;
    dgrant_o = d_win & ~reset;
  end

  // Alignment checks and store lane encoding for the data port.
  always_comb begin
    i_misalign = (iaddr_i[1:0] != 2'b00);
    d_be       = 4'b1111;
    d_wdata    = 32'h0;
    case (dsize_i)
      2'b00:   d_misalign = 1'b0;
      2'b01:   d_misalign = daddr_i[0];
      2'b10:   d_misalign = (daddr_i[1:0] != 2'b00);
      default: d_misalign = 1'b1;
    endcase
    if (dwe_i) begin
      case (dsize_i)
        2'b00: begin
          d_be    = 4'b0001 << daddr_i[1:0];
          d_wdata = {4{dwdata_i[7:0]}};
        end
        2'b01: begin
          d_be    = daddr_i[1] ? 4'b1100 : 4'b0011;
          d_wdata = {2{dwdata_i[15:0]}};
        end
        default: begin
          d_be    = 4'b1111;
          d_wdata = dwdata_i;
        end
      endcase
    end
  end

  // Next-state, payload latch, starvation and timeout counters.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    case (state_q)
      ST_IDLE: begin
        if (!ireq_i) begin
          starve_d = 4'd0;
        end
        if (i_win) begin
          owner_d  = 1'b0;
          addr_d   = {iaddr_i[31:2], 2'b00};
          we_d     = 1'b0;
          be_d     = 4'b1111;
          wdata_d  = 32'h0;
          starve_d = 4'd0;
          tmo_d    = 8'd0;
          state_d  = i_misalign ? ST_ERR : ST_REQ;
        end else if (d_win) begin
          owner_d = 1'b1;
          addr_d  = {daddr_i[31:2], 2'b00};
          we_d    = dwe_i;
          be_d    = d_be;
          wdata_d = d_wdata;
          tmo_d   = 8'd0;
          if (ireq_i) begin
            starve_d = starve_q + 4'd1;
          end
          state_d = d_misalign ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        tmo_d = tmo_q + 8'd1;
        // Timeout takes priority over a late grant; any response is then dropped.
        if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        tmo_d = tmo_q + 8'd1;
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
      tmo_q    <= 8'd0;
      owner_q  <= 1'b0;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      be_q     <= 4'b0000;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  // Memory-side outputs: payload is only driven while a request is presented.
  always_comb begin
    in_req      = (state_q == ST_REQ);
    mem_req_o   = in_req;
    mem_we_o    = in_req & we_q;
    mem_addr_o  = in_req ? addr_q  : 32'h0;
    mem_wdata_o = in_req ? wdata_q : 32'h0;
    mem_be_o    = in_req ? be_q    : 4'b0000;
  end

  // Core-side responses: pass-through on completion, zero data on error.
  always_comb begin
    resp_hit  = (state_q == ST_RESP) & mem_rvalid_i;
    err_st    = (state_q == ST_ERR);
    irvalid_o = (resp_hit | err_st) & ~owner_q;
    drvalid_o = (resp_hit | err_st) & owner_q;
    ierr_o    = err_st & ~owner_q;
    derr_o    = err_st & owner_q;
    irdata_o  = (resp_hit & ~owner_q) ? mem_rdata_i : 32'h0;
    drdata_o  = (resp_hit & owner_q)  ? mem_rdata_i : 32'h0;
    busy_o    = (state_q != ST_IDLE);
    owner_o   = owner_q;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: table of data-port vectors plus
// hand-written sequences for arbitration, starvation, timeout and reset.
module tb_riscv_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        ireq_i;
  logic [31:0] iaddr_i;
  logic        igrant_o;
  logic        irvalid_o;
  logic [31:0] irdata_o;
  logic        ierr_o;
  logic        dreq_i;
  logic        dwe_i;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic [1:0]  dsize_i;
  logic        dgrant_o;
  logic        drvalid_o;
  logic [31:0] drdata_o;
  logic        derr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        owner_o;

  int nchecks = 0;
  int nerr    = 0;

  riscv_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .ireq_i       (ireq_i),
    .iaddr_i      (iaddr_i),
    .igrant_o     (igrant_o),
    .irvalid_o    (irvalid_o),
    .irdata_o     (irdata_o),
    .ierr_o       (ierr_o),
    .dreq_i       (dreq_i),
    .dwe_i        (dwe_i),
    .daddr_i      (daddr_i),
    .dwdata_i     (dwdata_i),
    .dsize_i      (dsize_i),
    .dgrant_o     (dgrant_o),
    .drvalid_o    (drvalid_o),
    .drdata_o     (drdata_o),
    .derr_o       (derr_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  size;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk1(input string name, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called one step after the grant edge; memory grants and answers at once.
  task automatic serve(input logic exp_owner, input logic [31:0] exp_addr, input logic [31:0] rd);
    #1;
    chk1("serve_mem_req", mem_req_o, 1'b1);
    chk32("serve_mem_addr", mem_addr_o, exp_addr);
    chk1("serve_owner", owner_o, exp_owner);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    #1;
    if (exp_owner) begin
      chk1("serve_drvalid", drvalid_o, 1'b1);
      chk32("serve_drdata", drdata_o, rd);
      chk1("serve_irvalid_idle", irvalid_o, 1'b0);
    end else begin
      chk1("serve_irvalid", irvalid_o, 1'b1);
      chk32("serve_irdata", irdata_o, rd);
      chk1("serve_drvalid_idle", drvalid_o, 1'b0);
    end
    step();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic want_i;

    vecs[0] = '{2'b00, 1'b1, 32'h0000_0203, 32'h0000_00AB, 1'b0, 32'h0000_0200, 4'b1000, 32'hABAB_ABAB};
    vecs[1] = '{2'b00, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0000_0100, 4'b0001, 32'h7878_7878};
    vecs[2] = '{2'b01, 1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF};
    vecs[3] = '{2'b01, 1'b1, 32'h0000_0300, 32'h0000_1234, 1'b0, 32'h0000_0300, 4'b0011, 32'h1234_1234};
    vecs[4] = '{2'b10, 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 1'b0, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D};
    vecs[5] = '{2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000};
    vecs[6] = '{2'b00, 1'b0, 32'h0000_0101, 32'h0000_0000, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000};
    vecs[7] = '{2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[8] = '{2'b01, 1'b1, 32'h0000_0105, 32'h0000_5555, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
    vecs[9] = '{2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};

    reset = 1'b1;
    ireq_i = 1'b0; iaddr_i = 32'h0;
    dreq_i = 1'b0; dwe_i = 1'b0; daddr_i = 32'h0; dwdata_i = 32'h0; dsize_i = 2'b10;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset state: all outputs zero even with both requests raised.
    #12;
    ireq_i = 1'b1; dreq_i = 1'b1;
    #1;
    chk1("rst_igrant", igrant_o, 1'b0);
    chk1("rst_dgrant", dgrant_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_owner", owner_o, 1'b0);
    chk1("rst_drvalid", drvalid_o, 1'b0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    ireq_i = 1'b0; dreq_i = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step();

    // Table of data-port transactions.
    for (int i = 0; i < 10; i++) begin
      dreq_i = 1'b1; dwe_i = vecs[i].we; daddr_i = vecs[i].addr;
      dwdata_i = vecs[i].wdata; dsize_i = vecs[i].size;
      #1;
      chk1("vec_dgrant", dgrant_o, 1'b1);
      chk1("vec_igrant", igrant_o, 1'b0);
      step();
      dreq_i = 1'b0;
      #1;
      if (vecs[i].exp_err) begin
        chk1("vec_err_drvalid", drvalid_o, 1'b1);
        chk1("vec_err_derr", derr_o, 1'b1);
        chk32("vec_err_drdata", drdata_o, 32'h0);
        chk1("vec_err_mem_req", mem_req_o, 1'b0);
        step();
        chk1("vec_err_drvalid_end", drvalid_o, 1'b0);
        chk1("vec_err_busy_end", busy_o, 1'b0);
      end else begin
        chk1("vec_mem_req", mem_req_o, 1'b1);
        chk32("vec_mem_addr", mem_addr_o, vecs[i].exp_addr);
        chk32("vec_mem_be", 32'(mem_be_o), 32'(vecs[i].exp_be));
        chk1("vec_mem_we", mem_we_o, vecs[i].we);
        if (vecs[i].we) chk32("vec_mem_wdata", mem_wdata_o, vecs[i].exp_wdata);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        #1;
        chk1("vec_mem_req_drop", mem_req_o, 1'b0);
        chk1("vec_drvalid_wait", drvalid_o, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1000_0000 + 32'(i);
        #1;
        chk1("vec_drvalid", drvalid_o, 1'b1);
        chk32("vec_drdata", drdata_o, 32'h1000_0000 + 32'(i));
        chk1("vec_derr", derr_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        chk1("vec_busy_end", busy_o, 1'b0);
      end
      chk1("vec_last_owner", owner_o, 1'b1);
    end

    // Data wins over a simultaneous instruction request; instruction next.
    ireq_i = 1'b1; iaddr_i = 32'h80;
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h100; dsize_i = 2'b10;
    #1;
    chk1("dw_dgrant", dgrant_o, 1'b1);
    chk1("dw_igrant", igrant_o, 1'b0);
    step();
    dreq_i = 1'b0;
    serve(1'b1, 32'h100, 32'h1111_2222);
    #1;
    chk1("dw_igrant_next", igrant_o, 1'b1);
    step();
    ireq_i = 1'b0;
    serve(1'b0, 32'h80, 32'h3333_4444);

    // Starvation bound: four data grants, then the instruction port, then data again.
    ireq_i = 1'b1; iaddr_i = 32'h84;
    dreq_i = 1'b1; daddr_i = 32'h100;
    for (int k = 0; k < 6; k++) begin
      want_i = (k == 4);
      #1;
      chk1("stv_igrant", igrant_o, want_i);
      chk1("stv_dgrant", dgrant_o, ~want_i);
      step();
      serve(~want_i, want_i ? 32'h84 : 32'h100, 32'hA000_0000 + 32'(k));
    end
    ireq_i = 1'b0; dreq_i = 1'b0;

    // Misaligned instruction fetch goes straight to an error response.
    ireq_i = 1'b1; iaddr_i = 32'h82;
    #1;
    chk1("imis_igrant", igrant_o, 1'b1);
    step();
    ireq_i = 1'b0;
    #1;
    chk1("imis_irvalid", irvalid_o, 1'b1);
    chk1("imis_ierr", ierr_o, 1'b1);
    chk32("imis_irdata", irdata_o, 32'h0);
    chk1("imis_mem_req", mem_req_o, 1'b0);
    step();

    // Timeout: memory never grants; error 8 cycles after mem_req_o rises.
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h40; dsize_i = 2'b10;
    #1;
    chk1("tmo_dgrant", dgrant_o, 1'b1);
    step();
    dreq_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk1("tmo_no_drvalid", drvalid_o, 1'b0);
      chk1("tmo_mem_req", mem_req_o, 1'b1);
      step();
    end
    #1;
    chk1("tmo_drvalid", drvalid_o, 1'b1);
    chk1("tmo_derr", derr_o, 1'b1);
    chk32("tmo_drdata", drdata_o, 32'h0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_0001;
    #1;
    chk1("tmo_stray_drvalid", drvalid_o, 1'b0);
    chk1("tmo_stray_irvalid", irvalid_o, 1'b0);
    chk1("tmo_stray_busy", busy_o, 1'b0);
    step();
    mem_rvalid_i = 1'b0;

    // Reset asserted in RESP abandons the transaction immediately.
    dreq_i = 1'b1; daddr_i = 32'h60;
    #1;
    step();
    dreq_i = 1'b0;
    #1;
    chk1("rr_mem_req", mem_req_o, 1'b1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #1;
    chk1("rr_busy_resp", busy_o, 1'b1);
    reset = 1'b1; ireq_i = 1'b1; dreq_i = 1'b1;
    #1;
    chk1("rr_busy", busy_o, 1'b0);
    chk1("rr_mem_req0", mem_req_o, 1'b0);
    chk1("rr_drvalid", drvalid_o, 1'b0);
    chk1("rr_dgrant", dgrant_o, 1'b0);
    chk1("rr_igrant", igrant_o, 1'b0);
    chk1("rr_owner", owner_o, 1'b0);
    chk32("rr_mem_addr", mem_addr_o, 32'h0);
    ireq_i = 1'b0; dreq_i = 1'b0;
    reset = 1'b0;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_0002;
    #1;
    chk1("rr_stray_drvalid", drvalid_o, 1'b0);
    chk1("rr_stray_irvalid", irvalid_o, 1'b0);
    chk1("rr_stray_busy", busy_o, 1'b0);
    step();
    mem_rvalid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
